// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start bit, LSB-first payload, optional parity,
// one or two stop bits, with optional back-to-back framing at the bit rate.
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter bit B2B_EN     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  final_stop;
  logic                  accept;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;

    final_stop = (state_q == S_STOP2) || ((state_q == S_STOP1) && !stop2_q);
    accept     = Data_Valid && ((state_q == S_IDLE) || (B2B_EN && final_stop));

    case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? S_PARITY : S_STOP1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: state_d = S_STOP1;
      S_STOP1:  state_d = stop2_q ? S_STOP2 : S_IDLE;
      S_STOP2:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Accept is only possible in IDLE or the final stop bit, so it overrides the walk above.
    if (accept) begin
      state_d  = S_START;
      shift_d  = P_DATA;
      par_en_d = PAR_EN;
      par_d    = (^P_DATA) ^ PAR_TYP;
      stop2_d  = STOP2;
    end
  end

  // Outputs are decoded from the next state so the registered line matches the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP2) || ((state_d == S_STOP1) && !stop2_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TX_OUT     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: four instances cover width 8 with and
// without back-to-back framing, and widths 5 and 9.
module tb_uart_tx_frame_gen;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid;
  logic [7:0] d8;
  logic [4:0] d5;
  logic [8:0] d9;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int total = 0;
  int bad   = 0;

  uart_tx_frame_gen #(.DATA_WIDTH(8), .B2B_EN(1'b1)) dut_b2b (
    .CLK(clk), .RST(rst_n), .P_DATA(d8), .Data_Valid(valid[0]),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
  );

  uart_tx_frame_gen #(.DATA_WIDTH(8), .B2B_EN(1'b0)) dut_gap (
    .CLK(clk), .RST(rst_n), .P_DATA(d8), .Data_Valid(valid[1]),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
  );

  uart_tx_frame_gen #(.DATA_WIDTH(5), .B2B_EN(1'b1)) dut_w5 (
    .CLK(clk), .RST(rst_n), .P_DATA(d5), .Data_Valid(valid[2]),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2])
  );

  uart_tx_frame_gen #(.DATA_WIDTH(9), .B2B_EN(1'b1)) dut_w9 (
    .CLK(clk), .RST(rst_n), .P_DATA(d9), .Data_Valid(valid[3]),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the outputs of instance sel right now, without waiting for an edge.
  task automatic check_now(input int sel, input logic tx, input logic bz, input logic dn,
                           input string tag);
    check($sformatf("%s tx", tag),   32'(tx_w[sel]),   32'(tx));
    check($sformatf("%s busy", tag), 32'(busy_w[sel]), 32'(bz));
    check($sformatf("%s done", tag), 32'(done_w[sel]), 32'(dn));
  endtask

  task automatic check_cycle(input int sel, input logic tx, input logic bz, input logic dn,
                             input string tag);
    @(posedge clk);
    #1;
    check_now(sel, tx, bz, dn, tag);
  endtask

  // One frame already accepted: seq bit i is the line level in cycle i, done on the last.
  task automatic expect_frame(input int sel, input logic [31:0] seq, input int n,
                              input string tag);
    for (int i = 0; i < n; i++) begin
      check_cycle(sel, seq[i], 1'b1, (i == n - 1), $sformatf("%s c%0d", tag, i));
      if (i == 0) valid[sel] = 1'b0;
    end
    check_cycle(sel, 1'b1, 1'b0, 1'b0, $sformatf("%s idle", tag));
  endtask

  initial begin
    logic [31:0] seq;

    rst_n   = 1'b0;
    valid   = '0;
    d8      = '0;
    d5      = '0;
    d9      = '0;
    par_en  = 1'b0;
    par_typ = 1'b0;
    stop2   = 1'b0;

    // Reset state on every instance.
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) check_now(s, 1'b1, 1'b0, 1'b0, $sformatf("reset%0d", s));
    rst_n = 1'b1;
    check_cycle(0, 1'b1, 1'b0, 1'b0, "post_reset_idle");

    // Even parity, one stop: 0xA5 has four ones.
    d8 = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; valid[0] = 1'b1;
    seq = {21'd0, 1'b1, 1'b0, 8'hA5, 1'b0};
    expect_frame(0, seq, 11, "even1");

    // Odd parity, two stops: 0x07 has three ones, so odd parity bit is 0.
    d8 = 8'h07; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; valid[0] = 1'b1;
    seq = {20'd0, 2'b11, 1'b0, 8'h07, 1'b0};
    expect_frame(0, seq, 12, "odd2");

    // Back-to-back with B2B_EN=1: 0x3C then 0xC3, no parity, one stop.
    d8 = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; valid[0] = 1'b1;
    seq = {12'd0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 20; i++) begin
      check_cycle(0, seq[i], 1'b1, (i == 9) || (i == 19), $sformatf("b2b c%0d", i));
      if (i == 0) d8 = 8'hC3;
      if (i == 10) valid[0] = 1'b0;
    end
    check_cycle(0, 1'b1, 1'b0, 1'b0, "b2b idle");

    // Same pair with B2B_EN=0: exactly one idle cycle between the frames.
    d8 = 8'h3C; valid[1] = 1'b1;
    seq = {12'd0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check_cycle(1, seq[i], 1'b1, (i == 9), $sformatf("gap f1 c%0d", i));
      if (i == 0) d8 = 8'hC3;
    end
    check_cycle(1, 1'b1, 1'b0, 1'b0, "gap idle");
    for (int i = 10; i < 20; i++) begin
      check_cycle(1, seq[i], 1'b1, (i == 19), $sformatf("gap f2 c%0d", i));
      if (i == 10) valid[1] = 1'b0;
    end
    check_cycle(1, 1'b1, 1'b0, 1'b0, "gap end idle");

    // Ignored request: 0x55, even parity (0), two stops; a 0xFF request mid-frame changes nothing.
    d8 = 8'h55; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; valid[0] = 1'b1;
    seq = {20'd0, 2'b11, 1'b0, 8'h55, 1'b0};
    for (int i = 0; i < 12; i++) begin
      check_cycle(0, seq[i], 1'b1, (i == 11), $sformatf("ign c%0d", i));
      if (i == 0) valid[0] = 1'b0;
      if (i == 3) begin
        d8 = 8'hFF; par_en = 1'b0; par_typ = 1'b1; stop2 = 1'b0; valid[0] = 1'b1;
      end
      if (i == 4) valid[0] = 1'b0;
    end
    check_cycle(0, 1'b1, 1'b0, 1'b0, "ign idle0");
    check_cycle(0, 1'b1, 1'b0, 1'b0, "ign idle1");

    // Mid-frame reset during DATA cycle 4 of a 0x00 frame.
    d8 = 8'h00; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_cycle(0, 1'b0, 1'b1, 1'b0, $sformatf("rst pre c%0d", i));
      if (i == 0) valid[0] = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_now(0, 1'b1, 1'b0, 1'b0, "rst async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_cycle(0, 1'b1, 1'b0, 1'b0, "rst released idle");

    // Fresh frame after reset: 0x81, even parity (0), one stop.
    d8 = 8'h81; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; valid[0] = 1'b1;
    seq = {21'd0, 1'b1, 1'b0, 8'h81, 1'b0};
    expect_frame(0, seq, 11, "after_rst");

    // Width sweep: all-ones payload, even parity (1 for odd count of ones), two stops.
    d5 = 5'h1F; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; valid[2] = 1'b1;
    seq = {24'd0, 2'b11, 1'b1, 5'h1F, 1'b0};
    expect_frame(2, seq, 9, "w5");

    d9 = 9'h1FF; valid[3] = 1'b1;
    seq = {19'd0, 2'b11, 1'b1, 9'h1FF, 1'b0};
    expect_frame(3, seq, 13, "w9");
    check_cycle(3, 1'b1, 1'b0, 1'b0, "w9 idle2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
